// File: rtl/mem_ctrl.sv
// mem_ctrl: memory-access sequencer between the CPU datapath and a 512x32
// synchronous RAM. It holds the MAR and MDR and runs one load or store at a
// time. It also absorbs the RAM's one-cycle registered read latency.
module mem_ctrl #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              clear_n,
  input  logic [DATA_W-1:0] BusMuxOut,
  input  logic              MARin,
  input  logic              MDRin,
  input  logic              mem_start,
  input  logic              mem_we,
  output logic              busy,
  output logic              mem_done,
  output logic [DATA_W-1:0] BusMuxInMDR,
  output logic              ram_read,
  output logic              ram_write,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_RD_ISSUE   = 3'd1,
    S_RD_CAPTURE = 3'd2,
    S_WR_ISSUE   = 3'd3,
    S_DONE       = 3'd4
  } state_t;

  state_t              r_state;
  logic [ADDR_W-1:0]   r_mar;
  logic [DATA_W-1:0]   r_mdr;
  logic                r_busy;
  logic                r_mem_done;
  logic                r_ram_read;
  logic                r_ram_write;

  // Sequencer, MAR/MDR registers and registered strobes.
  // The strobes are loaded with the value belonging to the next state.
  // As a result they change together with r_state, and the asynchronous
  // reset clears them at the same instant.
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      r_state     <= S_IDLE;
      r_mar       <= '0;
      r_mdr       <= '0;
      r_busy      <= 1'b0;
      r_mem_done  <= 1'b0;
      r_ram_read  <= 1'b0;
      r_ram_write <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          // Register loads are accepted only here.
          // A start in the same cycle therefore uses the newly loaded
          // values, because the access begins on the following cycle.
          if (MARin) r_mar <= BusMuxOut[ADDR_W-1:0];
          if (MDRin) r_mdr <= BusMuxOut;
          if (mem_start) begin
            r_busy <= 1'b1;
            if (mem_we) begin
              r_state     <= S_WR_ISSUE;
              r_ram_write <= 1'b1;
            end else begin
              r_state    <= S_RD_ISSUE;
              r_ram_read <= 1'b1;
            end
          end
        end
        S_RD_ISSUE: begin
          r_state    <= S_RD_CAPTURE;
          r_ram_read <= 1'b0;
        end
        S_RD_CAPTURE: begin
          // The RAM word becomes valid one cycle after the read strobe.
          r_mdr      <= ram_rdata;
          r_state    <= S_DONE;
          r_mem_done <= 1'b1;
        end
        S_WR_ISSUE: begin
          r_state     <= S_DONE;
          r_ram_write <= 1'b0;
          r_mem_done  <= 1'b1;
        end
        S_DONE: begin
          r_state    <= S_IDLE;
          r_mem_done <= 1'b0;
          r_busy     <= 1'b0;
        end
        default: begin
          r_state     <= S_IDLE;
          r_busy      <= 1'b0;
          r_mem_done  <= 1'b0;
          r_ram_read  <= 1'b0;
          r_ram_write <= 1'b0;
        end
      endcase
    end
  end

  assign busy        = r_busy;
  assign mem_done    = r_mem_done;
  assign ram_read    = r_ram_read;
  assign ram_write   = r_ram_write;
  assign ram_addr    = r_mar;
  assign ram_wdata   = r_mdr;
  assign BusMuxInMDR = r_mdr;

endmodule

// File: tb/tb_mem_ctrl.sv
// Testbench for mem_ctrl. It contains a behavioural RAM that the DUT drives.
// A transaction-level reference model tracks MAR, MDR and a cycle count
// since the start of each access. A compare process checks every output
// on each falling edge. Directed scenarios add literal expectations.
module tb_mem_ctrl;

  logic        clock;
  logic        clear_n;
  logic [31:0] BusMuxOut;
  logic        MARin, MDRin, mem_start, mem_we;
  logic        busy, mem_done, ram_read, ram_write;
  logic [31:0] BusMuxInMDR, ram_wdata, ram_rdata;
  logic [8:0]  ram_addr;

  int tests = 0;
  int fails = 0;
  int done_cnt = 0;
  bit cmp_en = 0;

  mem_ctrl #(.ADDR_W(9), .DATA_W(32)) dut (
    .clock(clock), .clear_n(clear_n), .BusMuxOut(BusMuxOut),
    .MARin(MARin), .MDRin(MDRin), .mem_start(mem_start), .mem_we(mem_we),
    .busy(busy), .mem_done(mem_done), .BusMuxInMDR(BusMuxInMDR),
    .ram_read(ram_read), .ram_write(ram_write), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  initial clock = 0;
  always #5 clock = ~clock;

  // Environment RAM: 512x32 with a registered read. Its contents survive reset.
  logic [31:0] env_mem [512];
  always @(posedge clock) begin
    if (ram_write) env_mem[ram_addr] <= ram_wdata;
    if (ram_read)  ram_rdata <= env_mem[ram_addr];
  end

  // Reference model. ph counts the cycles since the accepted start
  // (0 = idle). A load lasts 3 busy cycles and a store lasts 2.
  logic [31:0] ref_mem [512];
  logic [8:0]  m_mar;
  logic [31:0] m_mdr;
  int          ph;
  bit          m_we;

  always @(posedge clock or negedge clear_n) begin
    int last;
    if (!clear_n) begin
      m_mar <= '0; m_mdr <= '0; ph <= 0; m_we <= 0;
    end else if (ph == 0) begin
      if (MARin) m_mar <= BusMuxOut[8:0];
      if (MDRin) m_mdr <= BusMuxOut;
      if (mem_start) begin ph <= 1; m_we <= mem_we; end
    end else begin
      last = m_we ? 2 : 3;
      ph <= (ph == last) ? 0 : ph + 1;
      if (m_we && ph == 1)  ref_mem[m_mar] <= m_mdr;
      if (!m_we && ph == 2) m_mdr <= ref_mem[m_mar];
      if (ph == last)
        $display("[TB] txn %s addr=%03h data=%08h", m_we ? "store" : "load ", m_mar, m_mdr);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // Compare process: all outputs against the model, once per cycle.
  always @(negedge clock) begin
    if (cmp_en) begin
      check("busy",      {31'd0, busy},      {31'd0, ph != 0});
      check("mem_done",  {31'd0, mem_done},  {31'd0, (m_we ? ph == 2 : ph == 3)});
      check("ram_read",  {31'd0, ram_read},  {31'd0, (!m_we && ph == 1)});
      check("ram_write", {31'd0, ram_write}, {31'd0, (m_we && ph == 1)});
      check("ram_addr",  {23'd0, ram_addr},  {23'd0, m_mar});
      check("ram_wdata", ram_wdata,          m_mdr);
      check("mdr_out",   BusMuxInMDR,        m_mdr);
    end
  end

  always @(negedge clock) if (mem_done) done_cnt++;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    BusMuxOut = '0; MARin = 0; MDRin = 0; mem_start = 0; mem_we = 0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"},  {31'd0, busy},      32'd0);
    check({tag, "_done"},  {31'd0, mem_done},  32'd0);
    check({tag, "_read"},  {31'd0, ram_read},  32'd0);
    check({tag, "_write"}, {31'd0, ram_write}, 32'd0);
    check({tag, "_addr"},  {23'd0, ram_addr},  32'd0);
    check({tag, "_wdata"}, ram_wdata,          32'd0);
    check({tag, "_mdr"},   BusMuxInMDR,        32'd0);
  endtask

  // Loads MAR and then MDR in two IDLE cycles.
  task automatic load_regs(input logic [31:0] a, input logic [31:0] d);
    BusMuxOut = a; MARin = 1; tick(); MARin = 0;
    BusMuxOut = d; MDRin = 1; tick(); MDRin = 0;
  endtask

  initial begin
    for (int i = 0; i < 512; i++) begin
      env_mem[i] = $urandom;
      ref_mem[i] = env_mem[i];
    end
    idle_inputs();
    clear_n = 0;
    repeat (2) tick();
    clear_n = 1;
    check_all_zero("rst0");
    cmp_en = 1;
    tick();

    // Store 0xDEADBEEF to 0x057: one write cycle, then done.
    load_regs(32'h0000_0057, 32'hDEAD_BEEF);
    mem_start = 1; mem_we = 1; tick(); mem_start = 0;
    check("st_write_c1", {31'd0, ram_write}, 32'd1);
    check("st_addr_c1",  {23'd0, ram_addr},  32'h057);
    check("st_data_c1",  ram_wdata,          32'hDEAD_BEEF);
    tick();
    check("st_write_c2", {31'd0, ram_write}, 32'd0);
    check("st_done_c2",  {31'd0, mem_done},  32'd1);
    tick();
    check("st_busy_c3",  {31'd0, busy},      32'd0);

    // Clear MDR, then load 0x057 back.
    BusMuxOut = 0; MDRin = 1; tick(); MDRin = 0;
    check("mdr_cleared", BusMuxInMDR, 32'd0);
    mem_start = 1; mem_we = 0; tick(); mem_start = 0;
    check("ld_read_c1", {31'd0, ram_read}, 32'd1);
    tick();
    check("ld_done_c2", {31'd0, mem_done}, 32'd0);
    tick();
    check("ld_done_c3", {31'd0, mem_done}, 32'd1);
    check("ld_mdr_c3",  BusMuxInMDR,       32'hDEAD_BEEF);
    tick();

    // Address truncation.
    BusMuxOut = 32'hFFFF_FE2A; MARin = 1; tick(); MARin = 0;
    check("addr_trunc", {23'd0, ram_addr}, 32'h02A);

    // Put a known word at 0x05F for the lockout test.
    load_regs(32'h0000_005F, 32'hCAFE_F00D);
    mem_start = 1; mem_we = 1; tick(); mem_start = 0;
    tick(); tick();
    BusMuxOut = 0; MDRin = 1; BusMuxOut = 32'h0000_0001; MARin = 1; tick();
    MDRin = 0;

    // Same-cycle MAR load with a load start. Busy lockout follows.
    done_cnt = 0;
    BusMuxOut = 32'h0000_005F; MARin = 1; mem_start = 1; mem_we = 0; tick();
    check("same_read_c1", {31'd0, ram_read}, 32'd1);
    check("same_addr_c1", {23'd0, ram_addr}, 32'h05F);
    BusMuxOut = 32'h0000_0100; MARin = 1; mem_start = 1; tick();
    BusMuxOut = 32'h1234_5678; MARin = 0; MDRin = 1; mem_start = 1; tick();
    idle_inputs();
    check("lock_done",  {31'd0, mem_done},  32'd1);
    check("lock_mar",   {23'd0, ram_addr},  32'h05F);
    check("lock_mdr",   BusMuxInMDR,        32'hCAFE_F00D);
    repeat (4) tick();
    check("lock_busy",  {31'd0, busy},      32'd0);
    check("lock_ndone", done_cnt,           32'd1);

    // Reset mid-store: 0x057 must keep 0xDEADBEEF.
    load_regs(32'h0000_0057, 32'h1111_1111);
    mem_start = 1; mem_we = 1; tick(); mem_start = 0;
    check("mr_write_c1", {31'd0, ram_write}, 32'd1);
    #2 clear_n = 0;
    #1 check_all_zero("mr");
    tick();
    clear_n = 1;
    BusMuxOut = 32'h0000_0057; MARin = 1; tick(); MARin = 0;
    mem_start = 1; mem_we = 0; tick(); mem_start = 0;
    tick(); tick();
    check("mr_old_data", BusMuxInMDR, 32'hDEAD_BEEF);
    tick();

    // Randomised traffic, checked by the compare process.
    for (int c = 0; c < 1500; c++) begin
      BusMuxOut = $urandom;
      MARin     = ($urandom_range(0, 3) == 0);
      MDRin     = ($urandom_range(0, 3) == 0);
      mem_start = ($urandom_range(0, 2) == 0);
      mem_we    = $urandom_range(0, 1);
      tick();
    end

    // Asynchronous reset mid-cycle with random inputs.
    BusMuxOut = $urandom; MARin = 1; MDRin = 1; mem_start = 1; mem_we = $urandom_range(0, 1);
    #3 clear_n = 0;
    #1 check_all_zero("arst");
    tick();
    clear_n = 1;
    idle_inputs();
    #1 check("arst_busy_after", {31'd0, busy}, 32'd0);
    repeat (3) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_ctrl.md
# mem_ctrl

Memory-access sequencer between the CPU datapath and the 512×32 synchronous RAM. Holds the MAR and MDR, accepts one load or store request at a time from the control unit, drives the RAM's read/write/address/data pins and absorbs the RAM's one-cycle registered read latency. On a load it captures the returned word into MDR; the MDR value always drives the bus-mux MDR input.

## Interface

Parameters:
- ADDR_W, 9: RAM address width; MAR width.
- DATA_W, 32: data word width; MDR width.

Ports:
- clock  in  1  system clock; all state updates on rising edge.
- clear_n  in  1  asynchronous, active-low reset.
- BusMuxOut  in  DATA_W  datapath bus.
- MARin  in  1  load MAR from BusMuxOut[ADDR_W-1:0]; upper bits ignored.
- MDRin  in  1  load MDR from BusMuxOut.
- mem_start  in  1  request a memory operation; sampled only in IDLE.
- mem_we  in  1  operation type, sampled with mem_start: 1 = store, 0 = load.
- busy  out  1  high in every state except IDLE.
- mem_done  out  1  one-cycle pulse when the operation completes.
- BusMuxInMDR  out  DATA_W  current MDR contents.
- ram_read  out  1  RAM read strobe.
- ram_write  out  1  RAM write strobe.
- ram_addr  out  ADDR_W  RAM address; always equals MAR.
- ram_wdata  out  DATA_W  RAM write data; always equals MDR.
- ram_rdata  in  DATA_W  RAM registered read data; valid the cycle after ram_read.

## Operation

- States: IDLE, RD_ISSUE, RD_CAPTURE, WR_ISSUE, DONE.
- IDLE: mem_start=1 and mem_we=0 -> RD_ISSUE. mem_start=1 and mem_we=1 -> WR_ISSUE. Otherwise stay in IDLE.
- RD_ISSUE: ram_read=1 for exactly one cycle -> RD_CAPTURE.
- RD_CAPTURE: MDR <= ram_rdata at the closing edge -> DONE.
- WR_ISSUE: ram_write=1 for exactly one cycle; RAM writes MDR to mem[MAR] at the closing edge -> DONE.
- DONE: mem_done=1 -> IDLE.
- ram_read and ram_write are decoded from state (Moore) and are never high together.
- MARin and MDRin are honoured only in IDLE. While busy they are ignored, so MAR and MDR stay stable through an access. The only exception is the FSM's own MDR capture in RD_CAPTURE.
- MARin/MDRin in the same IDLE cycle as mem_start: the registers load at that edge, and the launched operation uses the newly loaded values.
- mem_start while busy is ignored and not queued. The control unit must wait for mem_done.
- MDRin and MARin together in the same cycle: both load from the same BusMuxOut (the address takes the low ADDR_W bits).

## Timing

- Reset (clear_n=0, asynchronous): state=IDLE, MAR=0, MDR=0, busy=0, mem_done=0, ram_read=0, ram_write=0, ram_addr=0, ram_wdata=0, BusMuxInMDR=0. All take effect immediately, without a clock edge.
- Reset during RD_ISSUE or RD_CAPTURE: the load is aborted and MDR is 0. Reset during WR_ISSUE before the edge: no RAM write occurs.
- Load latency, with mem_start sampled at edge 0: RD_ISSUE in cycle 1, RD_CAPTURE in cycle 2, DONE in cycle 3 with mem_done=1 and MDR already holding the RAM word. IDLE in cycle 4. This is 4 cycles from start to the next accepted start.
- Store latency: WR_ISSUE in cycle 1, DONE in cycle 2 with mem_done=1 and the RAM already updated. IDLE in cycle 3.
- busy is high exactly while state is not IDLE, so it is low again in the cycle after mem_done.
- Back-to-back operations: mem_start may be asserted in the first IDLE cycle after DONE. No idle bubble is required beyond that.

## Test plan

- Reset: hold clear_n=0 mid-cycle with random inputs -> all outputs 0 immediately; after release, state is IDLE and busy=0.
- Store then load: MARin with BusMuxOut=0x00000057, MDRin with 0xDEADBEEF, store -> ram_write high for exactly one cycle with addr 0x057 and data 0xDEADBEEF. Clear MDR to 0 via MDRin, then load from 0x057 -> mem_done in cycle 3 and BusMuxInMDR=0xDEADBEEF.
- Address truncation: MARin with BusMuxOut=0xFFFFFE2A -> ram_addr=0x02A.
- Same-cycle load plus start: MARin with 0x05F together with mem_start (mem_we=0) -> ram_read asserted with ram_addr=0x05F in cycle 1.
- Busy lockout: during a load, pulse MARin with 0x100, MDRin with 0x12345678 and mem_start -> MAR is unchanged, MDR ends with the RAM word, no second operation starts, and mem_done pulses exactly once.
- Reset mid-store: assert clear_n=0 during WR_ISSUE before the edge -> ram_write drops immediately; reading that address afterwards returns its old contents.
